// File: rtl/freecell_pkg.sv
// Shared definitions for the freecell player and its move sequencer.
//   - move location encoding: 0jjj = column j, 10ii = free cell i, 11xx = home
//   - NOP move (source 11xx is never a legal source, so the player ignores it)
//   - sequencer state constants
//   - 6-bit card encoding used by the player
package freecell_pkg;

    localparam logic       LOC_COL  = 1'b0;
    localparam logic [1:0] LOC_FREE = 2'b10;
    localparam logic [1:0] LOC_HOME = 2'b11;

    localparam logic [3:0] NOP_LOC  = 4'b1100;
    localparam logic [7:0] NOP_MOVE = {NOP_LOC, NOP_LOC};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_WON   = 2'd3;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

    // A move may only start from a column or a free cell, never from home.
    function automatic logic src_legal(input logic [3:0] loc);
        return loc[3:2] != LOC_HOME;
    endfunction

endpackage

// File: rtl/freecell_move_fifo.sv
// Synchronous (source,dest) move FIFO.
//   clock, reset_n : clock, async active-low reset
//   push_i/wdata_i : enqueue request and 8-bit move {source,dest}
//   pop_i          : dequeue request; rdata_o is the current head
//   flush_i        : empty the FIFO (overrides push/pop)
//   full_o/empty_o/count_o : fill status
module freecell_move_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [7:0]                 wdata_i,
    output logic [7:0]                 rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // When full, a simultaneous pop frees the head slot, which is exactly
    // where the write pointer sits, so the push can land there.
    assign do_pop  = pop_i  && !flush_i && !empty_o;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
            else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/freecell_move_sequencer.sv
// Buffers (source,dest) moves and issues them to the freecell player one at
// a time, each followed by a NOP slot so the player commits the move and
// updates win before the next issue.
//   clock, reset_n            : clock, async active-low reset
//   push, push_source/dest    : enqueue a move (source 11xx rejected)
//   start                     : begin issuing (IDLE only)
//   abort                     : back to IDLE, flush FIFO, clear move_count
//   win                       : win flag from the player
//   source, dest              : registered move to the player (NOP = 1100/1100)
//   full, empty, occupancy    : FIFO status
//   busy, done                : state is ISSUE/GAP, state is WON
//   move_count, reject_count  : saturating counters
//
// state | meaning
// IDLE  | waiting for start, drives NOP
// ISSUE | pops and drives the head move, or stalls with NOP when empty
// GAP   | NOP slot while the player commits the last move
// WON   | player has won, no more pops until abort/reset
module freecell_move_sequencer
    import freecell_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [3:0]                 push_source,
    input  logic [3:0]                 push_dest,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       win,
    output logic [3:0]                 source,
    output logic [3:0]                 dest,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           move_count,
    output logic [CNT_W-1:0]           reject_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       move_q, move_d;
    logic [CNT_W-1:0] move_cnt_q, move_cnt_d;
    logic [CNT_W-1:0] rej_cnt_q, rej_cnt_d;
    logic [7:0]       head;
    logic             pop, push_ok, push_rej;

    assign pop      = (state_q == ST_ISSUE) && !win && !empty && !abort;
    assign push_ok  = push && !abort && src_legal(push_source) && (!full || pop);
    assign push_rej = push && !abort && !push_ok;

    freecell_move_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (push_ok),
        .pop_i   (pop),
        .flush_i (abort),
        .wdata_i ({push_source, push_dest}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (occupancy)
    );

    always_comb begin
        state_d    = state_q;
        move_d     = NOP_MOVE;
        move_cnt_d = move_cnt_q;
        rej_cnt_d  = rej_cnt_q;

        if (push_rej && rej_cnt_q != '1) rej_cnt_d = rej_cnt_q + CNT_ONE;

        if (abort) begin
            state_d    = ST_IDLE;
            move_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_ISSUE;
                ST_ISSUE: begin
                    if (win) begin
                        state_d = ST_WON;
                    end else if (!empty) begin
                        move_d  = head;
                        state_d = ST_GAP;
                        if (move_cnt_q != '1) move_cnt_d = move_cnt_q + CNT_ONE;
                    end
                end
                ST_GAP:   state_d = win ? ST_WON : ST_ISSUE;
                default:  state_d = ST_WON;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            move_q     <= NOP_MOVE;
            move_cnt_q <= '0;
            rej_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            move_q     <= move_d;
            move_cnt_q <= move_cnt_d;
            rej_cnt_q  <= rej_cnt_d;
        end
    end

    assign source       = move_q[7:4];
    assign dest         = move_q[3:0];
    assign busy         = (state_q == ST_ISSUE) || (state_q == ST_GAP);
    assign done         = (state_q == ST_WON);
    assign move_count   = move_cnt_q;
    assign reject_count = rej_cnt_q;

endmodule
